// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared register codes, FSM encodings and helpers for the register-transfer sequencer.
// The default data width comes from `REG_WIDTH when it is defined; otherwise it is 8.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package reg_xfer_ctrl_pkg;

  // Register-file codes; the mux has 16 inputs, but only 0..7 are writable.
  localparam int unsigned REG_A        = 0;
  localparam int unsigned REG_X        = 1;
  localparam int unsigned REG_Y        = 2;
  localparam int unsigned REG_S        = 3;
  localparam int unsigned REG_P        = 4;
  localparam int unsigned REG_PCL      = 5;
  localparam int unsigned REG_PCH      = 6;
  localparam int unsigned REG_DB       = 7;
  localparam int unsigned REG_CODE_MAX = 7;

  typedef enum logic [1:0] {
    XFER_IDLE    = 2'd0,
    XFER_SELECT  = 2'd1,
    XFER_CAPTURE = 2'd2,
    XFER_WRITE   = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer: drives the mux selector, captures mux output, issues one write.
// Optional N/Z flag generation is built only when XFER_FLAGS_EN is defined.
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int SIGNAL_WIDTH   = `REG_WIDTH,
  parameter int SELECTOR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SELECTOR_WIDTH-1:0] req_src,
  input  logic [SELECTOR_WIDTH-1:0] req_dst,
  output logic [SELECTOR_WIDTH-1:0] selector,
  input  logic [SIGNAL_WIDTH-1:0]   mux_out,
  output logic                      wr_en,
  output logic [SELECTOR_WIDTH-1:0] wr_addr,
  output logic [SIGNAL_WIDTH-1:0]   wr_data,
  output logic                      flag_we,
  output logic                      flag_n,
  output logic                      flag_z,
  output logic                      done,
  output logic                      err
);

  xfer_state_e               state;
  logic [SELECTOR_WIDTH-1:0] dst_q;
  logic                      dst_ok;

  // Codes above REG_CODE_MAX are readable through the mux but have no register behind them.
  assign dst_ok = (dst_q <= SELECTOR_WIDTH'(REG_CODE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= XFER_IDLE;
      req_ready <= 1'b1;
      selector  <= '0;
      dst_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        XFER_IDLE: begin
          if (req_valid && req_ready) begin
            selector  <= req_src;
            dst_q     <= req_dst;
            req_ready <= 1'b0;
            state     <= XFER_SELECT;
          end
        end
        XFER_SELECT: state <= XFER_CAPTURE;
        // Strobes are registered here, so they are visible for exactly the WRITE cycle.
        XFER_CAPTURE: begin
          wr_data <= mux_out;
          wr_addr <= dst_q;
          wr_en   <= dst_ok;
          done    <= 1'b1;
          err     <= ~dst_ok;
          state   <= XFER_WRITE;
        end
        XFER_WRITE: begin
          req_ready <= 1'b1;
          state     <= XFER_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= XFER_IDLE;
        end
      endcase
    end
  end

`ifdef XFER_FLAGS_EN
  // TXS leaves the flags untouched, so the stack-pointer destination suppresses flag_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_we <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      flag_we <= 1'b0;
      if (state == XFER_CAPTURE) begin
        flag_n  <= mux_out[SIGNAL_WIDTH-1];
        flag_z  <= (mux_out == '0);
        flag_we <= dst_ok && (dst_q != SELECTOR_WIDTH'(REG_S));
      end
    end
  end
`else
  assign flag_we = 1'b0;
  assign flag_n  = 1'b0;
  assign flag_z  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed table-driven bench for reg_xfer_ctrl; a 16-entry register array models the mux.
module tb_reg_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src, req_dst, selector, wr_addr;
  logic [7:0] mux_out, wr_data;
  logic       wr_en, flag_we, flag_n, flag_z, done, err;

  logic [7:0] regs [16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always_comb mux_out = regs[selector];

  reg_xfer_ctrl #(.SIGNAL_WIDTH(8), .SELECTOR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .selector(selector), .mux_out(mux_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z),
    .done(done), .err(err)
  );

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    logic [7:0] val;
    logic       we;
    logic       n;
    logic       z;
    logic       fwe;
    logic       er;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag outputs only carry information in the flags-enabled build.
  function automatic logic fx(input logic v);
`ifdef XFER_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_xfer(input vec_t v);
    int cyc;
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    regs[v.src] = v.val;
    req_valid = 1'b1; req_src = v.src; req_dst = v.dst;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sel_after_accept", selector, v.src);
    chk("ready_busy", req_ready, 0);
    cyc = 1;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 3);
    chk("sel_held", selector, v.src);
    chk("wr_en", wr_en, v.we);
    chk("err", err, v.er);
    chk("wr_addr", wr_addr, v.dst);
    chk("wr_data", wr_data, v.val);
    chk("flag_we", flag_we, fx(v.fwe));
    chk("flag_n", flag_n, fx(v.n));
    chk("flag_z", flag_z, fx(v.z));
    @(negedge clk);
    chk("strobes_clear", {wr_en, done, err, flag_we}, 0);
    chk("ready_after", req_ready, 1);
    chk("wr_data_hold", wr_data, v.val);
  endtask

  initial begin
    int t;
    logic seen;
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3);
    vecs[0] = '{4'd0,  4'd1,  8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // TAX negative
    vecs[1] = '{4'd1,  4'd3,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // TXS, no flags
    vecs[2] = '{4'd0,  4'd2,  8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // TAY zero
    vecs[3] = '{4'd2,  4'd9,  8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal dst
    vecs[4] = '{4'd2,  4'd2,  8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // src == dst
    vecs[5] = '{4'd12, 4'd7,  8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // high src to DB
    vecs[6] = '{4'd3,  4'd1,  8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // TSX
    vecs[7] = '{4'd1,  4'd15, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // illegal dst 15

    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {selector, wr_en, wr_addr, wr_data, flag_we, flag_n, flag_z, done, err}, 0);
    chk("rst_ready", req_ready, 1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en || done || err || flag_we || !req_ready) seen = 1'b1;
    end
    chk("idle_quiet", seen, 0);

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Back-to-back: req_valid held high, second request taken 4 cycles after the first.
    @(negedge clk);
    regs[4] = 8'hC3; regs[5] = 8'h00;
    req_valid = 1'b1; req_src = 4'd4; req_dst = 4'd0;
    for (t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t < 4) chk("b2b_ready_low", req_ready, 0);
      if (t == 3) chk("b2b_done1", {done, wr_data}, {1'b1, 8'hC3});
    end
    chk("b2b_ready_t4", req_ready, 1);
    req_src = 4'd5; req_dst = 4'd6;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_sel", selector, 4'd5);
    chk("b2b_second_busy", req_ready, 0);
    t = 0;
    while (!done && t < 8) begin @(negedge clk); t++; end
    chk("b2b_second_lat", t, 2);
    chk("b2b_second_wr", {wr_en, wr_addr, wr_data}, {1'b1, 4'd6, 8'h00});
    chk("b2b_second_z", flag_z, fx(1'b1));

    // Reset during CAPTURE abandons the transfer.
    @(negedge clk);
    regs[0] = 8'h33;
    req_valid = 1'b1; req_src = 4'd0; req_dst = 4'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en || done) seen = 1'b1;
    end
    chk("midrst_no_strobe", seen, 0);
    chk("midrst_state", {req_ready, wr_data, selector}, {1'b1, 8'h00, 4'd0});
    do_xfer('{4'd0, 4'd1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
